// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: flit type codes, widths and FIFO word field offsets.
package noc_pkg;

    localparam int NOC_DATA_W = 64;
    localparam int NOC_FLIT_W = 34;
    localparam int NOC_CNT_W  = 16;
    localparam int BODY_W     = 32;

    // FIFO word layout: {dst_y, dst_x} in the upper half, payload in the lower half
    localparam int DST_LSB     = 32;
    localparam int PAYLOAD_LSB = 0;

    typedef logic [1:0] flit_type_t;
    localparam flit_type_t FLIT_HEAD = 2'b01;
    localparam flit_type_t FLIT_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HEAD,
        ST_TAIL
    } pk_state_t;

endpackage

// File: rtl/gp_fifo.sv
// Generic synchronous FIFO; data_out is registered and valid the cycle after rd_en.
// Latency: one cycle write-to-nonempty, one cycle rd_en-to-data.
// Backpressure: full/empty flags; writes when full and reads when empty are dropped and pulse error.
module gp_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] data_in,
    input  logic         rd_en,
    output logic [W-1:0] data_out,
    output logic         empty,
    output logic         full,
    output logic         error
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            error    <= 1'b0;
        end else begin
            error <= (wr_en & full) | (rd_en & empty);
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ni_fifo_packetizer.sv
// NI transmit read side: drains 64-bit FIFO words and emits each as a head/tail flit pair.
// Latency: rd_en at cycle 0, head valid at cycle 2, tail at cycle 3; one packet per 3 cycles sustained.
// Backpressure: flit held stable with valid high until flit_ready; no new read until the tail is accepted.
module ni_fifo_packetizer
    import noc_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_W,
    parameter int FLIT_W = NOC_FLIT_W,
    parameter int CNT_W  = NOC_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic              fifo_error,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              err
);

    pk_state_t         state;
    pk_state_t         state_nxt;
    logic [DATA_W-1:0] word_q;
    logic              word_ld;
    logic              cnt_inc;
    logic              rd_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            word_q  <= '0;
            pkt_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err | fifo_error;
            if (word_ld) begin
                word_q <= fifo_data;
            end
            if (cnt_inc) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_req     = 1'b0;
        word_ld    = 1'b0;
        cnt_inc    = 1'b0;
        flit_valid = 1'b0;
        flit_out   = '0;
        case (state)
            ST_IDLE: begin
                if (en && !fifo_empty) begin
                    rd_req    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                word_ld   = 1'b1;
                state_nxt = ST_HEAD;
            end
            ST_HEAD: begin
                flit_valid = 1'b1;
                flit_out   = {FLIT_HEAD, word_q[DST_LSB +: BODY_W]};
                if (flit_ready) begin
                    state_nxt = ST_TAIL;
                end
            end
            ST_TAIL: begin
                flit_valid = 1'b1;
                flit_out   = {FLIT_TAIL, word_q[PAYLOAD_LSB +: BODY_W]};
                if (flit_ready) begin
                    cnt_inc = 1'b1;
                    // Chain straight into the next word so back-to-back packets take 3 cycles
                    if (en && !fifo_empty) begin
                        rd_req    = 1'b1;
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A read issued in the reset cycle would pop a word the FSM is about to forget
    assign fifo_rd_en = rd_req & reset;

endmodule

// File: tb/tb_ni_fifo_packetizer.sv
// Self-checking bench: gp_fifo feeding ni_fifo_packetizer, router modelled as a ready driver.
module tb_ni_fifo_packetizer;

    logic        clk;
    logic        reset;
    logic        en;
    logic        wr_en;
    logic [63:0] data_in;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_error;
    logic [63:0] fifo_data;
    logic        fifo_rd_en;
    logic [33:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic [15:0] pkt_cnt;
    logic        err;

    gp_fifo #(.W(64), .DEPTH(16)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .rd_en    (fifo_rd_en),
        .data_out (fifo_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .error    (fifo_error)
    );

    ni_fifo_packetizer dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_error (fifo_error),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .pkt_cnt    (pkt_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic [33:0] head;
        logic [33:0] tail;
    } vec_t;

    vec_t        vt [4];
    logic [33:0] exp_q[$];
    int          rd_q[$];
    int          flit_cyc_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_flit  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name, input int budget);
        n_vec++;
        n_miss++;
        $display("FAIL %s: no completion within %0d cycles", name, budget);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (fifo_rd_en) begin
                rd_q.push_back(cyc);
                chk("rd_en_on_empty", 64'(fifo_empty), 64'd0);
            end
            if (prev_stall) begin
                chk("hold_valid", 64'(flit_valid), 64'd1);
                chk("hold_flit", 64'(flit_out), 64'(prev_flit));
            end
            if (flit_valid && flit_ready) begin
                flit_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL flit_extra: got %h, no flit expected", flit_out);
                end else begin
                    chk("flit", 64'(flit_out), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = flit_valid && !flit_ready;
            prev_flit  = flit_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_logs();
        rd_q.delete();
        flit_cyc_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        tick();
        tick();
        chk("rst_flit_valid", 64'(flit_valid), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic write_word(input logic [63:0] w, input bit expect_out, input int idx);
        wr_en   = 1'b1;
        data_in = w;
        if (expect_out) begin
            exp_q.push_back(vt[idx].head);
            exp_q.push_back(vt[idx].tail);
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || flit_valid) && k < budget) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0 || flit_valid) timeout(name, budget);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!flit_valid && k < budget) begin
            tick();
            k++;
        end
        if (!flit_valid) timeout(name, budget);
    endtask

    task automatic wait_tail(input string name, input int budget);
        int k = 0;
        logic [1:0] ft;
        ft = flit_out[33:32];
        while (!(flit_valid && ft == 2'b10) && k < budget) begin
            tick();
            ft = flit_out[33:32];
            k++;
        end
        if (!(flit_valid && ft == 2'b10)) timeout(name, budget);
    endtask

    initial begin
        vt[0] = '{64'h00010001_BBBBBBBB, 34'h1_00010001, 34'h2_BBBBBBBB};
        vt[1] = '{64'hA5A5A5A5_A5A5A5A5, 34'h1_A5A5A5A5, 34'h2_A5A5A5A5};
        vt[2] = '{64'h00000000_BBBBBBBB, 34'h1_00000000, 34'h2_BBBBBBBB};
        vt[3] = '{64'h00010001_CCCCCCCC, 34'h1_00010001, 34'h2_CCCCCCCC};

        reset      = 1'b0;
        en         = 1'b0;
        wr_en      = 1'b0;
        data_in    = '0;
        flit_ready = 1'b0;
        tick();
        do_reset();

        // Single packet, ready always high: latency and counter
        en         = 1'b1;
        flit_ready = 1'b1;
        write_word(vt[0].word, 1'b1, 0);
        wait_idle("t1_drain", 50);
        repeat (3) tick();
        chk("t1_rd_pulses", 64'(rd_q.size()), 64'd1);
        chk("t1_flits", 64'(flit_cyc_q.size()), 64'd2);
        if (rd_q.size() == 1 && flit_cyc_q.size() == 2) begin
            chk("t1_head_lat", 64'(flit_cyc_q[0] - rd_q[0]), 64'd2);
            chk("t1_tail_lat", 64'(flit_cyc_q[1] - flit_cyc_q[0]), 64'd1);
        end
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Head stalled for 3 cycles by the router
        do_reset();
        en         = 1'b1;
        flit_ready = 1'b0;
        write_word(vt[0].word, 1'b1, 0);
        wait_valid("t2_head", 20);
        repeat (3) begin
            chk("t2_head_held", 64'(flit_out), 64'(vt[0].head));
            tick();
        end
        chk("t2_no_accept", 64'(flit_cyc_q.size()), 64'd0);
        flit_ready = 1'b1;
        wait_idle("t2_drain", 50);
        repeat (3) tick();
        chk("t2_rd_pulses", 64'(rd_q.size()), 64'd1);
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Three back-to-back words
        do_reset();
        en         = 1'b1;
        flit_ready = 1'b1;
        for (int i = 1; i < 4; i++) write_word(vt[i].word, 1'b1, i);
        wait_idle("t3_drain", 100);
        repeat (3) tick();
        chk("t3_rd_pulses", 64'(rd_q.size()), 64'd3);
        if (rd_q.size() == 3) begin
            chk("t3_rd_gap0", 64'(rd_q[1] - rd_q[0]), 64'd3);
            chk("t3_rd_gap1", 64'(rd_q[2] - rd_q[1]), 64'd3);
        end
        chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);
        chk("t3_fifo_empty", 64'(fifo_empty), 64'd1);

        // Empty FIFO with en high
        do_reset();
        en = 1'b1;
        repeat (20) begin
            tick();
            chk("t4_rd_en", 64'(fifo_rd_en), 64'd0);
            chk("t4_valid", 64'(flit_valid), 64'd0);
        end
        chk("t4_err", 64'(err), 64'd0);

        // Reset while the tail is on the link
        do_reset();
        en         = 1'b1;
        flit_ready = 1'b1;
        write_word(vt[0].word, 1'b1, 0);
        wait_tail("t5_tail", 20);
        reset = 1'b0;
        exp_q.delete();
        tick();
        chk("t5_valid_rst", 64'(flit_valid), 64'd0);
        chk("t5_cnt_rst", 64'(pkt_cnt), 64'd0);
        reset = 1'b1;
        repeat (10) tick();
        chk("t5_flits", 64'(flit_cyc_q.size()), 64'd1);
        chk("t5_valid_after", 64'(flit_valid), 64'd0);

        // Overflow error is sticky; en dropped during head finishes the packet only
        do_reset();
        en         = 1'b0;
        flit_ready = 1'b0;
        write_word(vt[1].word, 1'b1, 1);
        for (int i = 1; i < 16; i++) write_word(vt[i % 4].word, 1'b0, 0);
        chk("t6_err_pre", 64'(err), 64'd0);
        write_word(64'hDEAD_BEEF_0000_0017, 1'b0, 0);
        repeat (2) tick();
        chk("t6_err_set", 64'(err), 64'd1);
        repeat (5) tick();
        chk("t6_err_sticky", 64'(err), 64'd1);
        en = 1'b1;
        wait_valid("t6_head", 20);
        en         = 1'b0;
        flit_ready = 1'b1;
        wait_idle("t6_drain", 50);
        repeat (10) tick();
        chk("t6_rd_pulses", 64'(rd_q.size()), 64'd1);
        chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("t6_fifo_nonempty", 64'(fifo_empty), 64'd0);
        chk("t6_err_hold", 64'(err), 64'd1);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
